// File: rtl/pc_next_unit_if.sv
// Fetch/execute-side signal bundle for pc_next_unit.
// The return-address-stack signals exist only when PCU_RAS_EN is defined.
interface pc_next_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_fetchReady;
  logic                  i_stall;
  logic                  i_step2;
  logic                  i_redirect;
  logic [1:0]            i_redirectOp;
  logic [ADDR_WIDTH-1:0] i_redirectPc;
  logic [ADDR_WIDTH-1:0] i_instIMM;
  logic [ADDR_WIDTH-1:0] i_regData;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_pcValid;
  logic                  o_flush;
  logic                  o_misaligned;
  logic [ADDR_WIDTH-1:0] o_badAddr;
`ifdef PCU_RAS_EN
  logic                  i_rasPush;
  logic                  i_rasPop;
  logic [ADDR_WIDTH-1:0] o_rasTop;
  logic                  o_rasValid;
`endif

  modport master (
`ifdef PCU_RAS_EN
    output i_rasPush, i_rasPop,
    input  o_rasTop, o_rasValid,
`endif
    output i_fetchReady, i_stall, i_step2, i_redirect, i_redirectOp,
    output i_redirectPc, i_instIMM, i_regData,
    input  o_pc, o_pcValid, o_flush, o_misaligned, o_badAddr
  );

  modport slave (
`ifdef PCU_RAS_EN
    input  i_rasPush, i_rasPop,
    output o_rasTop, o_rasValid,
`endif
    input  i_fetchReady, i_stall, i_step2, i_redirect, i_redirectOp,
    input  i_redirectPc, i_instIMM, i_regData,
    output o_pc, o_pcValid, o_flush, o_misaligned, o_badAddr
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered fetch-PC generator: sequential advance, execute redirects, misalignment halt.
// Optional return-address stack enabled by defining PCU_RAS_EN.
module pc_next_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter bit                    COMPRESSED   = 1'b0,
  parameter int                    RAS_DEPTH    = 4
) (
  input logic           i_clock,
  input logic           i_reset,
  pc_next_unit_if.slave bus
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH, ST_HALT} state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP4 = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] STEP2 = ADDR_WIDTH'(2);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  valid_q;
  logic                  flush_q;
  logic                  mis_q;
  logic [ADDR_WIDTH-1:0] bad_q;

  logic [ADDR_WIDTH-1:0] target;
  logic                  target_mis;
  logic [ADDR_WIDTH-1:0] seq_step;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    target     = (bus.i_redirectOp[1] ? bus.i_regData : bus.i_redirectPc)
               + (bus.i_redirectOp[0] ? bus.i_instIMM : STEP4);
    target_mis = 1'b0;
    if (bus.i_redirectOp == 2'b11) target[0] = 1'b0;
    if (COMPRESSED) target_mis = (bus.i_redirectOp != 2'b11) && target[0];
    else            target_mis = target[1];
    seq_step = (COMPRESSED && bus.i_step2) ? STEP2 : STEP4;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      if (state == ST_BOOT) begin
        state   <= ST_RUN;
        valid_q <= 1'b1;
      end else if (bus.i_redirect) begin
        // Redirect outranks stall and fetch, and is the only way out of HALT.
        valid_q <= 1'b0;
        if (target_mis) begin
          mis_q <= 1'b1;
          bad_q <= target;
          state <= ST_HALT;
        end else begin
          pc_q    <= target;
          flush_q <= 1'b1;
          state   <= ST_FLUSH;
        end
      end else if (state == ST_FLUSH) begin
        state   <= ST_RUN;
        valid_q <= 1'b1;
      end else if (state == ST_RUN && valid_q && bus.i_fetchReady && !bus.i_stall) begin
        pc_q <= pc_q + seq_step;
      end
    end
  end

  assign bus.o_pc         = pc_q;
  assign bus.o_pcValid    = valid_q;
  assign bus.o_flush      = flush_q;
  assign bus.o_misaligned = mis_q;
  assign bus.o_badAddr    = bad_q;

`ifdef PCU_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      ras_top;
  logic [CNT_W-1:0]      ras_count;
  logic                  ras_empty;
  logic                  ras_pop_ok;
  logic                  ras_replace;
  logic [ADDR_WIDTH-1:0] ras_push_val;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
  endfunction

  assign ras_empty    = (ras_count == '0);
  assign ras_pop_ok   = bus.i_rasPop && !ras_empty;
  assign ras_replace  = bus.i_rasPush && ras_pop_ok;
  assign ras_push_val = bus.i_redirectPc + STEP4;

  // Circular buffer: a push on a full stack silently overwrites the oldest slot.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ras_top   <= '0;
      ras_count <= '0;
    end else if (ras_replace) begin
      ras_top <= ras_top;
    end else if (bus.i_rasPush) begin
      ras_top <= ptr_inc(ras_top);
      if (ras_count != CNT_W'(RAS_DEPTH)) ras_count <= ras_count + CNT_W'(1);
    end else if (ras_pop_ok) begin
      ras_top   <= ptr_dec(ras_top);
      ras_count <= ras_count - CNT_W'(1);
    end
  end

  // NOTE: the stack storage is not reset; ras_count alone decides which entries are meaningful.
  always_ff @(posedge i_clock) begin
    if (bus.i_rasPush) ras_mem[ras_replace ? ras_top : ptr_inc(ras_top)] <= ras_push_val;
  end

  assign bus.o_rasTop   = ras_mem[ras_top];
  assign bus.o_rasValid = !ras_empty;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: one COMPRESSED=0 and one COMPRESSED=1 instance
// share stimulus; directed scenarios plus a randomized run against a behavioural model.
module tb_pc_next_unit;
  localparam int AW = 32;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  pc_next_unit_if #(.ADDR_WIDTH(AW)) ifa ();
  pc_next_unit_if #(.ADDR_WIDTH(AW)) ifb ();

  always #5 i_clock = ~i_clock;

  assign ifb.i_fetchReady = ifa.i_fetchReady;
  assign ifb.i_stall      = ifa.i_stall;
  assign ifb.i_step2      = ifa.i_step2;
  assign ifb.i_redirect   = ifa.i_redirect;
  assign ifb.i_redirectOp = ifa.i_redirectOp;
  assign ifb.i_redirectPc = ifa.i_redirectPc;
  assign ifb.i_instIMM    = ifa.i_instIMM;
  assign ifb.i_regData    = ifa.i_regData;
`ifdef PCU_RAS_EN
  assign ifb.i_rasPush    = ifa.i_rasPush;
  assign ifb.i_rasPop     = ifa.i_rasPop;
`endif

  pc_next_unit #(.ADDR_WIDTH(AW), .RESET_VECTOR(32'h0), .COMPRESSED(1'b0), .RAS_DEPTH(4))
    dut_a (.i_clock(i_clock), .i_reset(i_reset), .bus(ifa));
  pc_next_unit #(.ADDR_WIDTH(AW), .RESET_VECTOR(32'h0), .COMPRESSED(1'b1), .RAS_DEPTH(4))
    dut_b (.i_clock(i_clock), .i_reset(i_reset), .bus(ifb));

  // Observation vectors {pc, valid, flush, misaligned}
  function automatic logic [34:0] obs_a();
    return {ifa.o_pc, ifa.o_pcValid, ifa.o_flush, ifa.o_misaligned};
  endfunction
  function automatic logic [34:0] obs_b();
    return {ifb.o_pc, ifb.o_pcValid, ifb.o_flush, ifb.o_misaligned};
  endfunction

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.i_fetchReady = 1'b0;
    ifa.i_stall      = 1'b0;
    ifa.i_step2      = 1'b0;
    ifa.i_redirect   = 1'b0;
    ifa.i_redirectOp = 2'b00;
    ifa.i_redirectPc = '0;
    ifa.i_instIMM    = '0;
    ifa.i_regData    = '0;
`ifdef PCU_RAS_EN
    ifa.i_rasPush    = 1'b0;
    ifa.i_rasPop     = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    i_reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    #2;
    i_reset = 1'b1;
  endtask

  task automatic redirect(input logic [1:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rd);
    ifa.i_redirect   = 1'b1;
    ifa.i_redirectOp = op;
    ifa.i_redirectPc = pc;
    ifa.i_instIMM    = imm;
    ifa.i_regData    = rd;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if (obs_a() !== {32'h0, 3'b000} || ifa.o_badAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_a: got %h bad=%h expected %h bad=0", obs_a(), ifa.o_badAddr, {32'h0, 3'b000});
    end
    checks++;
    if (obs_b() !== {32'h0, 3'b000} || ifb.o_badAddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_b: got %h bad=%h expected %h bad=0", obs_b(), ifb.o_badAddr, {32'h0, 3'b000});
    end
    i_reset = 1'b1;
    #2;
    checks++;
    if (obs_a() !== {32'h0, 3'b000}) begin
      errors++;
      $display("FAIL boot_a: got %h expected %h", obs_a(), {32'h0, 3'b000});
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    ifa.i_fetchReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_a() !== {exp_pc[i], 3'b100} || obs_b() !== {exp_pc[i], 3'b100}) begin
        errors++;
        $display("FAIL seq_%0d: got a=%h b=%h expected %h", i, obs_a(), obs_b(), {exp_pc[i], 3'b100});
      end
    end
  endtask

  task automatic test_branch_redirect();
    redirect(2'b01, 32'h100, 32'hFFFF_FFF0, 32'h0);
    tick();
    checks++;
    if (obs_a() !== {32'hF0, 3'b010} || obs_b() !== {32'hF0, 3'b010}) begin
      errors++;
      $display("FAIL branch_flush: got a=%h b=%h expected %h", obs_a(), obs_b(), {32'hF0, 3'b010});
    end
    ifa.i_redirect = 1'b0;
    tick();
    checks++;
    if (obs_a() !== {32'hF0, 3'b100}) begin
      errors++;
      $display("FAIL branch_run: got %h expected %h", obs_a(), {32'hF0, 3'b100});
    end
    tick();
    checks++;
    if (obs_a() !== {32'hF4, 3'b100} || obs_b() !== {32'hF4, 3'b100}) begin
      errors++;
      $display("FAIL branch_adv: got a=%h b=%h expected %h", obs_a(), obs_b(), {32'hF4, 3'b100});
    end
  endtask

  task automatic test_misaligned_halt();
    redirect(2'b11, 32'h0, 32'h0, 32'h202);
    tick();
    checks++;
    if (obs_a() !== {32'hF4, 3'b001} || ifa.o_badAddr !== 32'h202) begin
      errors++;
      $display("FAIL halt_enter_a: got %h bad=%h expected %h bad=202", obs_a(), ifa.o_badAddr, {32'hF4, 3'b001});
    end
    checks++;
    if (obs_b() !== {32'h202, 3'b010}) begin
      errors++;
      $display("FAIL jalr_aligned_b: got %h expected %h", obs_b(), {32'h202, 3'b010});
    end
    ifa.i_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_a() !== {32'hF4, 3'b000} || ifa.o_badAddr !== 32'h202) begin
        errors++;
        $display("FAIL halt_hold_%0d: got %h bad=%h expected %h bad=202", i, obs_a(), ifa.o_badAddr, {32'hF4, 3'b000});
      end
    end
    redirect(2'b00, 32'h2FC, 32'h0, 32'h0);
    tick();
    checks++;
    if (obs_a() !== {32'h300, 3'b010} || obs_b() !== {32'h300, 3'b010}) begin
      errors++;
      $display("FAIL halt_exit: got a=%h b=%h expected %h", obs_a(), obs_b(), {32'h300, 3'b010});
    end
    ifa.i_redirect = 1'b0;
    tick();
    checks++;
    if (obs_a() !== {32'h300, 3'b100}) begin
      errors++;
      $display("FAIL halt_run: got %h expected %h", obs_a(), {32'h300, 3'b100});
    end
  endtask

  task automatic test_stall();
    ifa.i_stall = 1'b1;
    redirect(2'b00, 32'h3FC, 32'h0, 32'h0);
    tick();
    checks++;
    if (obs_a() !== {32'h400, 3'b010} || obs_b() !== {32'h400, 3'b010}) begin
      errors++;
      $display("FAIL stall_redirect: got a=%h b=%h expected %h", obs_a(), obs_b(), {32'h400, 3'b010});
    end
    ifa.i_redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_a() !== {32'h400, 3'b100}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, obs_a(), {32'h400, 3'b100});
      end
    end
    ifa.i_stall = 1'b0;
    tick();
    checks++;
    if (obs_a() !== {32'h404, 3'b100}) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", obs_a(), {32'h404, 3'b100});
    end
  endtask

  task automatic test_wrap();
    redirect(2'b01, 32'hFFFF_FFFA, 32'h4, 32'h0);
    tick();
    checks++;
    if (obs_b() !== {32'hFFFF_FFFE, 3'b010}) begin
      errors++;
      $display("FAIL wrap_target_b: got %h expected %h", obs_b(), {32'hFFFF_FFFE, 3'b010});
    end
    checks++;
    if (obs_a() !== {32'h404, 3'b001} || ifa.o_badAddr !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_mis_a: got %h bad=%h expected %h bad=fffffffe", obs_a(), ifa.o_badAddr, {32'h404, 3'b001});
    end
    ifa.i_redirect = 1'b0;
    ifa.i_step2    = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_b() !== {32'h0, 3'b100}) begin
      errors++;
      $display("FAIL wrap_b: got %h expected %h", obs_b(), {32'h0, 3'b100});
    end
    tick();
    checks++;
    if (obs_b() !== {32'h2, 3'b100} || obs_a() !== {32'h404, 3'b000}) begin
      errors++;
      $display("FAIL step2: got b=%h a=%h expected b=%h a=%h", obs_b(), obs_a(), {32'h2, 3'b100}, {32'h404, 3'b000});
    end
    ifa.i_step2 = 1'b0;
  endtask

  task automatic test_jalr_compressed();
    redirect(2'b11, 32'h0, 32'h0, 32'h1001);
    tick();
    checks++;
    if (obs_b() !== {32'h1000, 3'b010} || obs_a() !== {32'h1000, 3'b010}) begin
      errors++;
      $display("FAIL jalr_force: got b=%h a=%h expected %h", obs_b(), obs_a(), {32'h1000, 3'b010});
    end
    checks++;
    if (ifa.o_badAddr !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL bad_addr_held: got %h expected fffffffe", ifa.o_badAddr);
    end
    ifa.i_redirect = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_halt();
    redirect(2'b11, 32'h0, 32'h0, 32'h202);
    tick();
    redirect(2'b00, 32'h4FC, 32'h0, 32'h0);
    #2;
    i_reset = 1'b0;
    #1;
    checks++;
    if (obs_a() !== {32'h0, 3'b000} || ifa.o_badAddr !== 32'h0 || obs_b() !== {32'h0, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: got a=%h bad=%h b=%h expected all zero", obs_a(), ifa.o_badAddr, obs_b());
    end
    tick();
    i_reset = 1'b1;
    tick();
    checks++;
    if (obs_a() !== {32'h0, 3'b100} || obs_b() !== {32'h0, 3'b100}) begin
      errors++;
      $display("FAIL boot_ignores_redirect: got a=%h b=%h expected %h", obs_a(), obs_b(), {32'h0, 3'b100});
    end
    idle_inputs();
  endtask

  // Behavioural reference: instance 0 has COMPRESSED=0, instance 1 has COMPRESSED=1.
  typedef enum {M_BOOT, M_RUN, M_FLUSH, M_HALT} mode_t;
  mode_t       m_mode [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_bad  [2];
  bit          m_flush[2];
  bit          m_mis  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_BOOT; m_pc[k] = 32'h0; m_bad[k] = 32'h0;
      m_flush[k] = 1'b0; m_mis[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] base, offs, t;
    bit bad;
    for (int k = 0; k < 2; k++) begin
      m_flush[k] = 1'b0;
      m_mis[k]   = 1'b0;
      if (m_mode[k] == M_BOOT) begin
        m_mode[k] = M_RUN;
      end else if (ifa.i_redirect) begin
        base = ifa.i_redirectOp[1] ? ifa.i_regData : ifa.i_redirectPc;
        offs = ifa.i_redirectOp[0] ? ifa.i_instIMM : 32'd4;
        t = base + offs;
        if (ifa.i_redirectOp == 2'b11) t = t - (t % 2);
        if (k == 1) bad = (ifa.i_redirectOp != 2'b11) && (t % 2 == 1);
        else        bad = ((t / 2) % 2) == 1;
        if (bad) begin
          m_mis[k] = 1'b1; m_bad[k] = t; m_mode[k] = M_HALT;
        end else begin
          m_pc[k] = t; m_flush[k] = 1'b1; m_mode[k] = M_FLUSH;
        end
      end else if (m_mode[k] == M_RUN && ifa.i_fetchReady && !ifa.i_stall) begin
        m_pc[k] = m_pc[k] + ((k == 1 && ifa.i_step2) ? 32'd2 : 32'd4);
      end else if (m_mode[k] == M_FLUSH) begin
        m_mode[k] = M_RUN;
      end
    end
  endtask

  task automatic test_random();
    logic [34:0] got, exp;
    logic [31:0] got_bad;
    apply_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      ifa.i_fetchReady = ($urandom_range(0, 3) != 0);
      ifa.i_stall      = ($urandom_range(0, 4) == 0);
      ifa.i_step2      = $urandom_range(0, 1);
      ifa.i_redirect   = ($urandom_range(0, 5) == 0);
      ifa.i_redirectOp = 2'($urandom_range(0, 3));
      ifa.i_redirectPc = $urandom;
      ifa.i_instIMM    = $urandom;
      ifa.i_regData    = $urandom;
      if ($urandom_range(0, 2) != 0) ifa.i_redirectPc[1:0] = 2'b00;
      if ($urandom_range(0, 2) != 0) ifa.i_instIMM[1:0]    = 2'b00;
      if ($urandom_range(0, 2) != 0) ifa.i_regData[1:0]    = 2'b00;
      model_step();
      tick();
      for (int k = 0; k < 2; k++) begin
        got     = (k == 0) ? obs_a() : obs_b();
        got_bad = (k == 0) ? ifa.o_badAddr : ifb.o_badAddr;
        exp     = {m_pc[k], (m_mode[k] == M_RUN), m_flush[k], m_mis[k]};
        checks++;
        if (got !== exp || got_bad !== m_bad[k]) begin
          errors++;
          $display("FAIL random_%0d_c%0d: got %h bad=%h expected %h bad=%h", n, k, got, got_bad, exp, m_bad[k]);
        end
        checks++;
        if (got[1] && got[0]) begin
          errors++;
          $display("FAIL flush_mis_exclusive_%0d_c%0d: got flush=1 mis=1 expected not both", n, k);
        end
      end
    end
    idle_inputs();
  endtask

`ifdef PCU_RAS_EN
  task automatic test_ras();
    apply_reset();
    #1;
    checks++;
    if (ifa.o_rasValid !== 1'b0) begin
      errors++;
      $display("FAIL ras_reset: got valid=%b expected 0", ifa.o_rasValid);
    end
    for (int i = 0; i < 5; i++) begin
      ifa.i_rasPush    = 1'b1;
      ifa.i_redirectPc = 32'h0C + 32'h10 * i;
      tick();
    end
    ifa.i_rasPush = 1'b0;
    checks++;
    if (ifa.o_rasTop !== 32'h50 || ifa.o_rasValid !== 1'b1) begin
      errors++;
      $display("FAIL ras_overflow: got top=%h valid=%b expected top=50 valid=1", ifa.o_rasTop, ifa.o_rasValid);
    end
    for (int i = 0; i < 5; i++) begin
      ifa.i_rasPop = 1'b1;
      tick();
      checks++;
      if (i < 3) begin
        if (ifa.o_rasTop !== 32'h40 - 32'h10 * i || ifa.o_rasValid !== 1'b1) begin
          errors++;
          $display("FAIL ras_pop_%0d: got top=%h valid=%b expected top=%h valid=1", i, ifa.o_rasTop, ifa.o_rasValid, 32'h40 - 32'h10 * i);
        end
      end else if (ifa.o_rasValid !== 1'b0) begin
        errors++;
        $display("FAIL ras_empty_%0d: got valid=%b expected 0", i, ifa.o_rasValid);
      end
    end
    ifa.i_rasPop     = 1'b0;
    ifa.i_rasPush    = 1'b1;
    ifa.i_redirectPc = 32'h7C;
    tick();
    ifa.i_rasPop     = 1'b1;
    ifa.i_redirectPc = 32'h8C;
    tick();
    checks++;
    if (ifa.o_rasTop !== 32'h90 || ifa.o_rasValid !== 1'b1) begin
      errors++;
      $display("FAIL ras_replace: got top=%h valid=%b expected top=90 valid=1", ifa.o_rasTop, ifa.o_rasValid);
    end
    ifa.i_rasPush = 1'b0;
    tick();
    checks++;
    if (ifa.o_rasValid !== 1'b0) begin
      errors++;
      $display("FAIL ras_replace_count: got valid=%b expected 0", ifa.o_rasValid);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch_redirect();
    test_misaligned_halt();
    test_stall();
    test_wrap();
    test_jalr_compressed();
    test_reset_in_halt();
    test_random();
`ifdef PCU_RAS_EN
    test_ras();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Parametrised next-PC generator that supersedes the combinational PC adder. Holds the architectural fetch PC in a register and presents it to fetch with a valid/ready handshake. Advances it sequentially by 4, or by 2 for compressed instructions, and accepts redirects from execute (branch/JAL/JALR), with misalignment detection and a halt state. Sits between the execute stage and the instruction-fetch port.

Parameters:
ADDR_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, 0, PC value loaded at reset
COMPRESSED, 0, 1 = 16-bit instruction support (2-byte alignment, step of 2 allowed)
RAS_DEPTH, 4, return-address stack entries (only used with PCU_RAS_EN)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_fetchReady  in  1  fetch accepts o_pc this cycle
i_stall  in  1  pipeline stall; PC holds
i_step2  in  1  accepted instruction is 16-bit (ignored when COMPRESSED=0)
i_redirect  in  1  execute requests a redirect this cycle
i_redirectOp  in  2  bit1: base 0=i_redirectPc, 1=i_regData; bit0: offset 0=+4, 1=+i_instIMM
i_redirectPc  in  ADDR_WIDTH  PC of the redirecting instruction
i_instIMM  in  ADDR_WIDTH  sign-extended immediate
i_regData  in  ADDR_WIDTH  base register value
o_pc  out  ADDR_WIDTH  current fetch PC
o_pcValid  out  1  o_pc is valid for fetch
o_flush  out  1  one-cycle pulse: discard in-flight fetches
o_misaligned  out  1  one-cycle pulse: redirect target misaligned
o_badAddr  out  ADDR_WIDTH  offending target, held until the next misalignment

Behaviour:
- Reset (async assert, sync release): o_pc=RESET_VECTOR, o_pcValid=0, o_flush=0, o_misaligned=0, o_badAddr=0, state=BOOT.
- States:
  - BOOT: o_pcValid=0; next cycle goes to RUN.
  - RUN: o_pcValid=1.
  - FLUSH: o_pcValid=0, o_flush=1; next cycle goes to RUN.
  - HALT: o_pcValid=0; o_pc frozen.
- Target computation: target = base + offset, modulo 2^ADDR_WIDTH, wrap-around silently.
  - When i_redirectOp=2'b11 (JALR), bit0 of the target is forced to 0.
  - Op 2'b10 yields i_regData+4.
- Alignment check on the forced target:
  - COMPRESSED=0: misaligned if target[1]=1.
  - COMPRESSED=1: bit0 is always 0 after forcing, so no misalignment for JALR. For other ops, misaligned if target[0]=1.
- Priority each cycle: redirect > stall > sequential advance.
- Redirect in cycle N, any state except BOOT:
  - Aligned target: o_pc=target at N+1, state FLUSH at N+1, RUN at N+2.
  - Misaligned target: o_pc unchanged, o_misaligned=1 and o_badAddr=target at N+1, state HALT.
- Redirect during BOOT: ignored.
- In HALT, only an aligned redirect exits (HALT -> FLUSH). Stall and fetch inputs have no effect.
- Sequential advance: in RUN when o_pcValid && i_fetchReady && !i_stall && !i_redirect, o_pc <= o_pc + (COMPRESSED && i_step2 ? 2 : 4), 1-cycle latency. Otherwise o_pc holds.
- i_stall with i_redirect: redirect wins; the stall does not block the flush.
- Reset asserted mid-redirect or in HALT: immediately returns to BOOT values; the pending target is discarded.
- o_flush and o_misaligned are never high in the same cycle.

Optional Feature:
PCU_RAS_EN:
- Adds a return-address stack of RAS_DEPTH entries.
- Extra ports: i_rasPush (1), i_rasPop (1), o_rasTop (ADDR_WIDTH), o_rasValid (1).
- Push stores i_redirectPc+4.
- On overflow, the oldest entry is overwritten (circular buffer); the count saturates at RAS_DEPTH.
- Pop on an empty stack is ignored and o_rasValid stays 0.
- Simultaneous push and pop replaces the top entry; the count is unchanged.
- Reset empties the stack.
- Without the macro: no RAS ports and no RAS storage.

Test Plan:
- Reset release, i_fetchReady=1 for 3 cycles -> o_pcValid 0 then 1; o_pc = 0x0, 0x4, 0x8.
- i_redirect=1, op=01, i_redirectPc=0x100, i_instIMM=0xFFFFFFF0 -> next cycle o_pc=0xF0, o_flush=1, o_pcValid=0; following cycle o_pcValid=1.
- COMPRESSED=0, op=11, i_regData=0x202, imm=0 -> o_misaligned=1, o_badAddr=0x202, o_pc unchanged, HALT. A later redirect to 0x300 -> o_pc=0x300 and RUN.
- i_stall=1 together with an aligned redirect to 0x400 -> redirect taken, o_pc=0x400. i_stall=1 alone -> o_pc holds for all stall cycles.
- COMPRESSED=1, i_step2=1 at o_pc=0xFFFFFFFE -> o_pc wraps to 0x0; op=11, i_regData=0x1001 -> o_pc=0x1000, no misalignment.
- PCU_RAS_EN, RAS_DEPTH=4: 5 pushes of 0x10..0x50 -> o_rasTop=0x50. 4 pops empty the stack; a 5th pop leaves o_rasValid=0.
